// File: rtl/sum_tx_sequencer_if.sv
// Byte-wide UART transmit handshake between the report sequencer and uart_tx.
// The master drives the start strobe and byte; the slave reports busy.
interface sum_tx_sequencer_if;
  logic       uart_tx_en;
  logic [7:0] uart_tx_data;
  logic       uart_tx_busy;

  modport master (
    output uart_tx_en,
    output uart_tx_data,
    input  uart_tx_busy
  );

  modport slave (
    input  uart_tx_en,
    input  uart_tx_data,
    output uart_tx_busy
  );
endinterface

// File: rtl/sum_tx_sequencer.sv
// Debounces the A/B save buttons, captures two 4-bit operands, registers their
// sum and, on every accepted B save, sends the ASCII report "A+B=SS\r\n".
module sum_tx_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 save_a_n,
  input  logic                 save_b_n,
  input  logic [3:0]           data_input,
  sum_tx_sequencer_if.master   tx,
  output logic [3:0]           op_a,
  output logic [3:0]           op_b,
  output logic [4:0]           sum,
  output logic                 msg_active
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT_HI,
    S_WAIT_LO
  } state_t;

  function automatic logic [7:0] hex_ascii(input logic [3:0] v);
    return (v < 4'd10) ? (8'h30 + {4'h0, v}) : (8'h37 + {4'h0, v});
  endfunction

  function automatic logic [7:0] report_byte(
    input logic [2:0] idx,
    input logic [3:0] a,
    input logic [3:0] b,
    input logic [4:0] s
  );
    logic [7:0] r;
    case (idx)
      3'd0:    r = hex_ascii(a);
      3'd1:    r = 8'h2B;
      3'd2:    r = hex_ascii(b);
      3'd3:    r = 8'h3D;
      3'd4:    r = hex_ascii({3'b000, s[4]});
      3'd5:    r = hex_ascii(s[3:0]);
      3'd6:    r = 8'h0D;
      default: r = 8'h0A;
    endcase
    return r;
  endfunction

  // Two-stage synchronizers; bit 0 = A button, bit 1 = B button. Buttons idle high.
  logic [1:0] btn_s1_q, btn_s2_q;
  logic [3:0] data_s1_q, data_s2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_s1_q  <= 2'b11;
      btn_s2_q  <= 2'b11;
      data_s1_q <= 4'h0;
      data_s2_q <= 4'h0;
    end else begin
      btn_s1_q  <= {save_b_n, save_a_n};
      btn_s2_q  <= btn_s1_q;
      data_s1_q <= data_input;
      data_s2_q <= data_s1_q;
    end
  end

  logic [1:0] accept;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_debounce
      logic [CW-1:0] cnt_q, cnt_d;
      logic          armed_q, armed_d;
      logic          acc_q, acc_d;
      logic          settle;

      // While armed we count low cycles toward a press; once pressed we count
      // high cycles toward re-arming. Any glitch restarts the count.
      assign settle = armed_q ? ~btn_s2_q[gi] : btn_s2_q[gi];

      always_comb begin
        cnt_d   = cnt_q;
        armed_d = armed_q;
        acc_d   = 1'b0;
        if (settle) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            armed_d = ~armed_q;
            acc_d   = armed_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d = '0;
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_q   <= '0;
          armed_q <= 1'b1;
          acc_q   <= 1'b0;
        end else begin
          cnt_q   <= cnt_d;
          armed_q <= armed_d;
          acc_q   <= acc_d;
        end
      end

      assign accept[gi] = acc_q;
    end
  endgenerate

  state_t     state_q, state_d;
  logic [3:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [4:0] sum_q, sum_d;
  logic       req_q, req_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] snap_a_q, snap_a_d, snap_b_q, snap_b_d;
  logic [4:0] snap_s_q, snap_s_d;
  logic [7:0] data_q, data_d;
  logic       req_pend;

  // A B accept counts as pending in the same cycle so an idle FSM reaches LOAD
  // one cycle after the accept, by which time op_b already holds the new value.
  assign req_pend = req_q | accept[1];

  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    sum_d    = {1'b0, op_a_q} + {1'b0, op_b_q};
    idx_d    = idx_q;
    snap_a_d = snap_a_q;
    snap_b_d = snap_b_q;
    snap_s_d = snap_s_q;
    data_d   = data_q;
    req_d    = accept[1] | (req_q & (state_q != S_LOAD));

    if (accept[0]) op_a_d = data_s2_q;
    if (accept[1]) op_b_d = data_s2_q;

    case (state_q)
      S_IDLE: begin
        if (req_pend) state_d = S_LOAD;
      end
      S_LOAD: begin
        snap_a_d = op_a_q;
        snap_b_d = op_b_q;
        snap_s_d = {1'b0, op_a_q} + {1'b0, op_b_q};
        idx_d    = 3'd0;
        data_d   = hex_ascii(op_a_q);
        state_d  = S_SEND;
      end
      S_SEND: begin
        if (!tx.uart_tx_busy) state_d = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (tx.uart_tx_busy) state_d = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (!tx.uart_tx_busy) begin
          if (idx_q == 3'd7) begin
            state_d = req_pend ? S_LOAD : S_IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            data_d  = report_byte(idx_q + 3'd1, snap_a_q, snap_b_q, snap_s_q);
            state_d = S_SEND;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      op_a_q   <= 4'h0;
      op_b_q   <= 4'h0;
      sum_q    <= 5'h00;
      req_q    <= 1'b0;
      idx_q    <= 3'd0;
      snap_a_q <= 4'h0;
      snap_b_q <= 4'h0;
      snap_s_q <= 5'h00;
      data_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      sum_q    <= sum_d;
      req_q    <= req_d;
      idx_q    <= idx_d;
      snap_a_q <= snap_a_d;
      snap_b_q <= snap_b_d;
      snap_s_q <= snap_s_d;
      data_q   <= data_d;
    end
  end

  // The strobe is gated by live busy so it can never coincide with busy high,
  // and SEND is left after one strobe so it can never repeat back to back.
  assign tx.uart_tx_en   = (state_q == S_SEND) && !tx.uart_tx_busy;
  assign tx.uart_tx_data = data_q;
  assign op_a            = op_a_q;
  assign op_b            = op_b_q;
  assign sum             = sum_q;
  assign msg_active      = (state_q != S_IDLE);

endmodule
